// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the frequency counter gate/sequencing logic.
package freq_counter_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } gate_state_t;

   localparam int unsigned BCD_WIDTH           = 4;
   localparam int unsigned DEFAULT_DIGITS      = 6;
   localparam int unsigned DEFAULT_GATE_CYCLES = 10_000_000;

endpackage

// File: rtl/signal_edge_sync.sv
// Two-flop synchroniser for the measured signal followed by a registered
// rising-edge detector; edge_pulse is high for one clk_in cycle per rise.
module signal_edge_sync (
   input  logic clk_in,
   input  logic reset_in,
   input  logic signal_in,
   output logic edge_pulse
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic edge_q;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= signal_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         edge_q  <= sync2_q & ~prev_q;
      end
   end

   assign edge_pulse = edge_q;

endmodule

// File: rtl/freq_gate_controller.sv
// Gate window sequencer: clears the digit chain, counts synchronised edges for
// GATE_CYCLES cycles, then latches the BCD digits behind a valid/ready port.
module freq_gate_controller
   import freq_counter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
   parameter int unsigned DIGITS      = DEFAULT_DIGITS
) (
   input  logic                          clk_in,
   input  logic                          reset_in,
   input  logic                          signal_in,
   output logic                          count_reset_out,
   output logic                          count_enable_out,
   output logic                          count_pulse_out,
   input  logic [DIGITS*BCD_WIDTH-1:0]   digits_in,
   input  logic                          overflow_in,
   output logic [DIGITS*BCD_WIDTH-1:0]   result_out,
   output logic                          result_overflow_out,
   output logic                          result_valid_out,
   input  logic                          result_ready_in
);

   localparam int unsigned TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GATE_CYCLES - 1);

   gate_state_t                  state_q;
   logic [TIMER_W-1:0]           timer_q;
   logic                         sticky_q;
   logic [DIGITS*BCD_WIDTH-1:0]  result_q;
   logic                         result_ovf_q;
   logic                         valid_q;
   logic                         edge_pulse;

   signal_edge_sync u_edge_sync (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .signal_in  (signal_in),
      .edge_pulse (edge_pulse)
   );

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q      <= CLEAR;
         timer_q      <= '0;
         sticky_q     <= 1'b0;
         result_q     <= '0;
         result_ovf_q <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         // A LATCH below overrides this, so a coinciding transfer keeps valid high.
         if (valid_q && result_ready_in) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            CLEAR: begin
               timer_q  <= TIMER_LOAD;
               sticky_q <= 1'b0;
               state_q  <= GATE;
            end
            GATE: begin
               if (overflow_in) begin
                  sticky_q <= 1'b1;
               end
               if (timer_q == '0) begin
                  state_q <= LATCH;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            LATCH: begin
               result_q     <= digits_in;
               result_ovf_q <= sticky_q | overflow_in;
               valid_q      <= 1'b1;
               state_q      <= CLEAR;
            end
            default: begin
               state_q <= CLEAR;
            end
         endcase
      end
   end

   // Chain reset follows reset_in immediately so the digits clear with the controller.
   assign count_reset_out     = reset_in | (state_q == CLEAR);
   assign count_enable_out    = ~reset_in & (state_q == GATE);
   assign count_pulse_out     = ~reset_in & (state_q == GATE) & edge_pulse;
   assign result_out          = result_q;
   assign result_overflow_out = result_ovf_q;
   assign result_valid_out    = valid_q;

endmodule
